pipe_field: RTL and testbench

- Downstream consumer of the pipe pattern generator.
- Holds the scrolling playfield as COLS columns of 8-bit wall patterns:
  - samples the incoming pattern once per shift period;
  - scrolls the field one column left per shift;
  - detects bird/wall collision;
  - keeps a 2-digit BCD score.
- Drives the game-over signal fed back to the pattern generator and the display.

---
 rtl/pipe_field.sv | 129 ++++++++++++
 tb/tb_pipe_field.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_field.sv
// Scrolling playfield for the pipe game: column shifter, bird/wall collision, BCD score.
// Optional high-score register is built when PIPE_FIELD_HISCORE_EN is defined.
module pipe_field #(
    parameter int COLS         = 8,
    parameter int SHIFT_PERIOD = 256,
    parameter int BIRD_COL     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          pattern,
    input  logic [2:0]          bird_row,
    output logic [COLS*8-1:0]   field,
    output logic                shift_pulse,
    output logic                over,
    output logic [3:0]          score_ones,
    output logic [3:0]          score_tens,
    output logic [3:0]          hi_ones,
    output logic [3:0]          hi_tens
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam int            CW   = (SHIFT_PERIOD > 1) ? $clog2(SHIFT_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(SHIFT_PERIOD - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [7:0]    cols [COLS];
    logic          clear;
    logic          hit;
    logic          shift_now;
    logic          pass_now;
    logic          score_max;

    // start low behaves exactly like reset for everything except the high score
    assign clear     = reset | ~start;
    assign hit       = (state == RUN) && cols[BIRD_COL][bird_row];
    assign shift_now = (state == RUN) && (count == LAST) && !hit;
    assign pass_now  = shift_now && (cols[BIRD_COL] != 8'h00);
    assign score_max = (score_tens == 4'd9) && (score_ones == 4'd9);

    // NOTE: every clocked block uses non-blocking assignments so all registers
    // sample pre-edge values, which the column shift below depends on.
    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: default assignment first so no path through the case leaves
    // state_nxt unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     if (hit) state_nxt = DEAD;
            DEAD:    state_nxt = DEAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        over = 1'b0;
        if (state == DEAD) over = 1'b1;
    end

    // The counter freezes on the collision edge and stays frozen while DEAD
    always_ff @(posedge clk) begin
        if (clear)                      count <= '0;
        else if (state == RUN && !hit)  count <= (count == LAST) ? '0 : count + 1'b1;
    end

    // NOTE: this array is ordinary flops, not RAM, and must be cleared because
    // a soft restart has to blank the visible playfield.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int c = 0; c < COLS; c++) cols[c] <= 8'h00;
        end else if (shift_now) begin
            for (int c = 0; c < COLS - 1; c++) cols[c] <= cols[c+1];
            cols[COLS-1] <= pattern;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) shift_pulse <= 1'b0;
        else       shift_pulse <= shift_now;
    end

    // Saturating two-digit BCD score
    always_ff @(posedge clk) begin
        if (clear) begin
            score_ones <= 4'd0;
            score_tens <= 4'd0;
        end else if (pass_now && !score_max) begin
            if (score_ones == 4'd9) begin
                score_ones <= 4'd0;
                score_tens <= score_tens + 4'd1;
            end else begin
                score_ones <= score_ones + 4'd1;
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_flat
        assign field[c*8 +: 8] = cols[c];
    end

`ifdef PIPE_FIELD_HISCORE_EN
    // Survives start-low restarts; only the hard reset forgets the best score
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_ones <= 4'd0;
            hi_tens <= 4'd0;
        end else if (!clear && hit && ({score_tens, score_ones} > {hi_tens, hi_ones})) begin
            hi_ones <= score_ones;
            hi_tens <= score_tens;
        end
    end
`else
    assign hi_ones = 4'd0;
    assign hi_tens = 4'd0;
`endif

endmodule

// File: tb/tb_pipe_field.sv
// Directed bench for pipe_field with COLS=8, SHIFT_PERIOD=4, BIRD_COL=1.
module tb_pipe_field;

    localparam int COLS = 8;
    localparam int SP   = 4;
    localparam int BC   = 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         pattern = 8'h00;
    logic [2:0]         bird_row = 3'd0;
    logic [COLS*8-1:0]  field;
    logic               shift_pulse;
    logic               over;
    logic [3:0]         score_ones, score_tens, hi_ones, hi_tens;

    int                 total  = 0;
    int                 passed = 0;
    logic [COLS*8-1:0]  exp_field;
    int                 exp_score;
    logic [7:0]         exp_hi;

    pipe_field #(.COLS(COLS), .SHIFT_PERIOD(SP), .BIRD_COL(BC)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .bird_row(bird_row),
        .field(field), .shift_pulse(shift_pulse), .over(over),
        .score_ones(score_ones), .score_tens(score_tens),
        .hi_ones(hi_ones), .hi_tens(hi_tens)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Soft-clear via start low, then enter RUN with count at 0
    task automatic enter_run();
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
        exp_field = '0;
        exp_score = 0;
    endtask

    // Drive one column and wait for its shift; the DUT must be at count 0 on entry
    task automatic do_shift(input logic [7:0] pat, input string tag);
        int n;
        pattern = pat;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (shift_pulse !== 1'b1 && n < SP + 2);
        total++;
        if (shift_pulse !== 1'b1 || n != SP)
            $display("FAIL %s shift_latency got %0d cycles pulse=%b exp %0d cycles", tag, n, shift_pulse, SP);
        else passed++;
        if (exp_field[BC*8 +: 8] != 8'h00 && exp_score < 99) exp_score++;
        exp_field = {pat, exp_field[COLS*8-1:8]};
        total++;
        if (field !== exp_field) $display("FAIL %s field got %h exp %h", tag, field, exp_field);
        else passed++;
        total++;
        if ({score_tens, score_ones} !== to_bcd(exp_score))
            $display("FAIL %s score got %h exp %h", tag, {score_tens, score_ones}, to_bcd(exp_score));
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        tick(2);
        total++;
        if ({field, shift_pulse, over} !== {{(COLS*8){1'b0}}, 2'b00})
            $display("FAIL reset outputs got field=%h pulse=%b over=%b exp zeros", field, shift_pulse, over);
        else passed++;
        total++;
        if ({score_tens, score_ones, hi_tens, hi_ones} !== 16'h0000)
            $display("FAIL reset scores got %h exp 0000", {score_tens, score_ones, hi_tens, hi_ones});
        else passed++;
        reset = 1'b0;
        start = 1'b0;
        tick(1);
    endtask

    task automatic test_first_shift();
        bird_row = 3'd7;
        enter_run();
        for (int k = 1; k <= 7; k++) do_shift(8'hF3, "first_shift");
        total++;
        if (over !== 1'b0) $display("FAIL pre_hit_over got %b exp 0", over);
        else passed++;
        tick(1);
        total++;
        if (over !== 1'b1 || shift_pulse !== 1'b0)
            $display("FAIL hit_over got over=%b pulse=%b exp over=1 pulse=0", over, shift_pulse);
        else passed++;
        tick(6);
        total++;
        if (field !== exp_field || over !== 1'b1)
            $display("FAIL dead_freeze got field=%h over=%b exp %h over=1", field, over, exp_field);
        else passed++;
    endtask

    task automatic test_score();
        bird_row = 3'd3;
        enter_run();
        for (int k = 1; k <= 16; k++) do_shift((k % 2 == 1) ? 8'hE7 : 8'h00, "score");
        total++;
        if ({score_tens, score_ones} !== 8'h05 || over !== 1'b0)
            $display("FAIL score_05 got %h over=%b exp 05 over=0", {score_tens, score_ones}, over);
        else passed++;
    endtask

    task automatic test_saturate();
        bird_row = 3'd4;
        enter_run();
        for (int k = 1; k <= 107; k++) do_shift(8'h01, "saturate");
        total++;
        if ({score_tens, score_ones} !== 8'h99)
            $display("FAIL saturate_99 got %h exp 99", {score_tens, score_ones});
        else passed++;
    endtask

    task automatic test_hit_on_shift();
        bird_row = 3'd0;
        enter_run();
        for (int k = 1; k <= 8; k++) do_shift(8'h20, "hit_setup");
        tick(3);
        bird_row = 3'd5;
        pattern  = 8'hAA;
        tick(1);
        total++;
        if (field !== exp_field || over !== 1'b1 || shift_pulse !== 1'b0)
            $display("FAIL hit_on_shift got field=%h over=%b pulse=%b exp %h over=1 pulse=0",
                     field, over, shift_pulse, exp_field);
        else passed++;
        total++;
        if ({score_tens, score_ones} !== 8'h01)
            $display("FAIL hit_on_shift_score got %h exp 01", {score_tens, score_ones});
        else passed++;
        for (int r = 0; r < 8; r++) begin
            bird_row = 3'(r);
            tick(1);
        end
        total++;
        if (field !== exp_field || {score_tens, score_ones} !== 8'h01 || over !== 1'b1 || shift_pulse !== 1'b0)
            $display("FAIL dead_bird_toggle got field=%h score=%h over=%b pulse=%b exp %h 01 1 0",
                     field, {score_tens, score_ones}, over, shift_pulse, exp_field);
        else passed++;
    endtask

    task automatic test_soft_clear();
        bird_row = 3'd4;
        enter_run();
        for (int k = 1; k <= 19; k++) do_shift(8'h01, "soft_setup");
        tick(1);
        start = 1'b0;
        tick(1);
        total++;
        if (field !== '0 || {score_tens, score_ones} !== 8'h00 || over !== 1'b0 || shift_pulse !== 1'b0)
            $display("FAIL soft_clear got field=%h score=%h over=%b pulse=%b exp zeros",
                     field, {score_tens, score_ones}, over, shift_pulse);
        else passed++;
        start = 1'b1;
        tick(1);
        tick(3);
        total++;
        if (shift_pulse !== 1'b0) $display("FAIL restart_early_pulse got %b exp 0", shift_pulse);
        else passed++;
        tick(1);
        total++;
        if (shift_pulse !== 1'b1 || field !== {8'h01, {((COLS-1)*8){1'b0}}})
            $display("FAIL restart_shift got pulse=%b field=%h exp pulse=1 col7=01", shift_pulse, field);
        else passed++;
    endtask

    task automatic test_hiscore();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        bird_row = 3'd4;
        enter_run();
        for (int k = 1; k <= 14; k++) do_shift(8'h01, "hi_run1");
        bird_row = 3'd0;
        tick(1);
`ifdef PIPE_FIELD_HISCORE_EN
        exp_hi = 8'h07;
`else
        exp_hi = 8'h00;
`endif
        total++;
        if (over !== 1'b1 || {hi_tens, hi_ones} !== exp_hi)
            $display("FAIL hi_first got over=%b hi=%h exp over=1 hi=%h", over, {hi_tens, hi_ones}, exp_hi);
        else passed++;
        bird_row = 3'd4;
        enter_run();
        total++;
        if ({hi_tens, hi_ones} !== exp_hi)
            $display("FAIL hi_keep_on_start got %h exp %h", {hi_tens, hi_ones}, exp_hi);
        else passed++;
        for (int k = 1; k <= 10; k++) do_shift(8'h01, "hi_run2");
        bird_row = 3'd0;
        tick(1);
        total++;
        if (over !== 1'b1 || {score_tens, score_ones} !== 8'h03 || {hi_tens, hi_ones} !== exp_hi)
            $display("FAIL hi_lower got over=%b score=%h hi=%h exp over=1 score=03 hi=%h",
                     over, {score_tens, score_ones}, {hi_tens, hi_ones}, exp_hi);
        else passed++;
        reset = 1'b1;
        tick(1);
        total++;
        if ({hi_tens, hi_ones} !== 8'h00) $display("FAIL hi_reset got %h exp 00", {hi_tens, hi_ones});
        else passed++;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_shift();
        test_score();
        test_saturate();
        test_hit_on_shift();
        test_soft_clear();
        test_hiscore();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
